dpwm_gen: RTL
=============

// Module: dpwm_gen
// PURPOSE
//  Digital PWM stage directly downstream of the PID controller.
//  Converts the signed Q4.15 control word N_con into a duty count and drives a counter-compare PWM output.
//  Issues one pwm_tick per switching period; this tick is the f_pwm sample clock for the PID stage.
//  Duty changes take effect only at a period boundary, so a pulse is never cut short mid-period.
// PARAMETERS
//  CNT_W   8    counter width; PERIOD must be < 2**CNT_W
//  PERIOD  255  counter terminal value; switching period = PERIOD+1 f_clk cycles
//  D_MIN   0    minimum duty count applied (clamp floor)
//  D_MAX   242  maximum duty count applied (clamp ceiling); D_MIN <= D_MAX <= PERIOD+1
//  DT      4    dead-time cycles (used only with DPWM_DEADTIME_EN)
// PORTS
//  f_clk     in   1        fast DPWM clock, rising edge
//  rst       in   1        asynchronous, active-high reset
//  en        in   1        run enable
//  N_con     in   19 s     PID control word, Q4.15 (1.0 = 32768 = 100% duty)
//  pwm       out  1        PWM output, registered
//  pwm_tick  out  1        one-cycle pulse per period (PID sample clock)
//  duty_act  out  CNT_W+1  duty count in use this period
//  sat       out  1        set when the latched duty was clamped
// BEHAVIOUR
//  Reset (async, any cycle incl. mid-period):
//   - cnt=0, duty_act=D_MIN, pwm=0, pwm_tick=0, sat=0.
//   - Reset release behaves as en rising from cnt=0.
//  Counter:
//   - en=1: cnt increments 0..PERIOD, then wraps to 0.
//   - en=0: cnt held at 0.
//  Duty conversion (combinational, full signed width, no truncation before clamp):
//   - raw = (N_con * (PERIOD+1)) >>> 15 (floor).
//   - Clamp: raw<D_MIN -> D_MIN, sat_n=1; raw>D_MAX -> D_MAX, sat_n=1; else raw, sat_n=0.
//   - Negative N_con therefore clamps to D_MIN.
//  Double buffering:
//   - duty_act and sat load the clamped value when (en=1 & cnt==PERIOD), or every cycle while en=0.
//   - N_con changes at any other time are ignored until the next boundary.
//  Output timing (registered, one-cycle lag):
//   - pwm <= en & (cnt < duty_act).
//   - pwm_tick <= en & (cnt == PERIOD), so it is high in the first cycle of each new period.
//  Duty edge cases:
//   - duty_act=0: pwm low the whole period.
//   - duty_act=PERIOD+1: pwm high the whole period, no gap at wrap.
//  en fall: next edge pwm=0, pwm_tick=0, cnt=0.
//   - No partial-period tick is issued.
//   - First tick after re-enable: PERIOD+1 cycles after en rises.
//  Simultaneous load and N_con change at cnt==PERIOD: the value present at that edge is captured.
// CONFIGURATION
//  DPWM_DEADTIME_EN defined:
//   - Adds outputs pwm_h and pwm_l (1 bit each, registered).
//   - FSM states: S_OFF -> S_DT_LH -> S_HIGH -> S_DT_HL -> S_LOW -> S_DT_LH ...
//   - Each DT state lasts DT cycles with both outputs low; pwm_h=1 only in S_HIGH, pwm_l=1 only in S_LOW.
//   - Transitions follow pwm edges. A pwm edge during a DT state restarts that state toward the new level.
//   - en=0 or rst -> S_OFF (both low); S_OFF -> S_DT_LH when pwm=1, else -> S_DT_HL.
//   - pwm output is unchanged.
//  DPWM_DEADTIME_EN undefined: pwm_h, pwm_l and the FSM are absent; the block is pure counter-compare.
// TESTING (PERIOD=99, CNT_W=7, D_MIN=0, D_MAX=95, DT=3)
//  1. N_con=16384 (0.5), en=1 -> duty_act=50; pwm high 50 of every 100 cycles; pwm_tick every 100 cycles; sat=0.
//  2. N_con=-4096 -> duty_act=0, sat=1, pwm constantly 0; N_con=65536 (2.0) -> duty_act=95, sat=1.
//  3. N_con steps 16384->8192 at cnt=20 -> current period keeps 50 high cycles; next period has 25.
//  4. rst pulsed at cnt=60 -> same cycle: pwm=0, duty_act=0, cnt=0; after release first tick at cycle 100.
//  5. en low for 37 cycles mid-period -> pwm=0, no ticks; after en high the first tick comes 100 cycles later.
//  6. DPWM_DEADTIME_EN, N_con=16384 -> pwm_h high 47 cycles, pwm_l high 47 cycles, never both high; two 3-cycle gaps per period.

Source files
------------

// File: rtl/dpwm_gen.sv
// Counter-compare DPWM: converts a signed Q4.15 control word into a clamped duty count.
// The duty is double-buffered at period boundaries. Define DPWM_DEADTIME_EN for dead-time pwm_h_o/pwm_l_o.
module dpwm_gen #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PERIOD = 255,
  parameter int unsigned D_MIN  = 0,
  parameter int unsigned D_MAX  = 242,
  parameter int unsigned DT     = 4
) (
  input  logic               f_clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic signed [18:0] n_con_i,
  output logic               pwm_o,
  output logic               pwm_tick_o,
  output logic [CNT_W:0]     duty_act_o,
  output logic               sat_o
`ifdef DPWM_DEADTIME_EN
  ,
  output logic               pwm_h_o,
  output logic               pwm_l_o
`endif
);

  localparam int unsigned DW = CNT_W + 1;
  // Wide enough for the full product so the clamp sees the untruncated value.
  localparam int unsigned PW = CNT_W + 21;

  localparam logic [CNT_W-1:0]     CntMax  = CNT_W'(PERIOD);
  localparam logic signed [PW-1:0] Scale   = PW'(PERIOD + 1);
  localparam logic signed [PW-1:0] RawMin  = PW'(D_MIN);
  localparam logic signed [PW-1:0] RawMax  = PW'(D_MAX);
  localparam logic [DW-1:0]        DutyMin = DW'(D_MIN);
  localparam logic [DW-1:0]        DutyMax = DW'(D_MAX);

  logic signed [PW-1:0] prod, raw;
  logic [DW-1:0]        duty_n;
  logic                 sat_n;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    duty_q;
  logic             sat_q, pwm_q, tick_q;
  logic             at_end, load;

  always_comb begin
    prod = PW'(n_con_i) * Scale;
    raw  = prod >>> 15;
    if (raw < RawMin) begin
      duty_n = DutyMin;
      sat_n  = 1'b1;
    end else if (raw > RawMax) begin
      duty_n = DutyMax;
      sat_n  = 1'b1;
    end else begin
      duty_n = DW'(raw);
      sat_n  = 1'b0;
    end
  end

  always_comb begin
    at_end = (cnt_q == CntMax);
    load   = !en_i || at_end;
    cnt_d  = '0;
    if (en_i && !at_end) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge f_clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      duty_q <= DutyMin;
      sat_q  <= 1'b0;
      pwm_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (load) begin
        duty_q <= duty_n;
        sat_q  <= sat_n;
      end
      pwm_q  <= en_i && ({1'b0, cnt_q} < duty_q);
      tick_q <= en_i && at_end;
    end
  end

  assign pwm_o      = pwm_q;
  assign pwm_tick_o = tick_q;
  assign duty_act_o = duty_q;
  assign sat_o      = sat_q;

`ifdef DPWM_DEADTIME_EN
  localparam int unsigned DtW    = (DT > 1) ? $clog2(DT) : 1;
  localparam logic [DtW-1:0] DtLast = DtW'(DT - 1);

  typedef enum logic [2:0] {StOff, StDtLh, StHigh, StDtHl, StLow} state_e;

  state_e         st_q, st_d;
  logic [DtW-1:0] dt_q, dt_d;
  logic           pwm_h_q, pwm_l_q;

  // Follows the registered pwm; a reversed edge inside a dead-time window restarts it.
  always_comb begin
    st_d = st_q;
    dt_d = '0;
    if (!en_i) begin
      st_d = StOff;
    end else begin
      unique case (st_q)
        StOff:  st_d = pwm_q ? StDtLh : StDtHl;
        StDtLh: begin
          if (!pwm_q)               st_d = StDtHl;
          else if (dt_q == DtLast)  st_d = StHigh;
          else                      dt_d = dt_q + 1'b1;
        end
        StHigh: if (!pwm_q) st_d = StDtHl;
        StDtHl: begin
          if (pwm_q)                st_d = StDtLh;
          else if (dt_q == DtLast)  st_d = StLow;
          else                      dt_d = dt_q + 1'b1;
        end
        StLow:  if (pwm_q) st_d = StDtLh;
        default: st_d = StOff;
      endcase
    end
  end

  always_ff @(posedge f_clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q    <= StOff;
      dt_q    <= '0;
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      dt_q    <= dt_d;
      pwm_h_q <= (st_d == StHigh);
      pwm_l_q <= (st_d == StLow);
    end
  end

  assign pwm_h_o = pwm_h_q;
  assign pwm_l_o = pwm_l_q;
`endif

endmodule
